fp_div_seq: RTL and testbench

Sequential IEEE 754 single-precision divider: the inverse-operation companion to the combinational `fpm` multiplier in the FPU datapath. It accepts an operand pair on a `start` handshake and computes the 24-bit significand quotient by radix-2 restoring division, one bit per clock. It then normalises, rounds to nearest-even and returns `q = a / b` with a one-cycle `done` pulse. Subnormals are flushed to zero; there is no trap logic.

---
 rtl/fp_div_seq.sv | 203 ++++++++++++++++++++
 tb/tb_fp_div_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fp_div_seq.sv
// Sequential binary32 divider: radix-2 restoring, one quotient bit per clock.
// Optional IEEE exception flags output enabled with FPD_FLAGS_EN.
module fp_div_seq #(
  parameter int size = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [size-1:0] a,
  input  logic [size-1:0] b,
  output logic [size-1:0] q,
  output logic            busy,
  output logic            done
`ifdef FPD_FLAGS_EN
  ,
  output logic [4:0]      flags
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    DIV,
    RND
  } state_t;

  state_t state, nxt;

  logic [size-1:0] a_r, b_r;
  logic [4:0]      cnt;
  logic [24:0]     rem;
  logic [23:0]     mb;
  logic [25:0]     quo;
  logic signed [9:0] ex;
  logic            sgn;
  logic            spec;
  logic [31:0]     spec_q;
`ifdef FPD_FLAGS_EN
  logic [4:0]      spec_f;
`endif

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        za, zb, ia, ib, na, nb;
  logic        sgn_c;

  assign ea    = a_r[30:23];
  assign eb    = b_r[30:23];
  assign fa    = a_r[22:0];
  assign fb    = b_r[22:0];
  assign za    = (ea == 8'd0);
  assign zb    = (eb == 8'd0);
  assign ia    = (ea == 8'hFF) && (fa == 23'd0);
  assign ib    = (eb == 8'hFF) && (fb == 23'd0);
  assign na    = (ea == 8'hFF) && (fa != 23'd0);
  assign nb    = (eb == 8'hFF) && (fb != 23'd0);
  assign sgn_c = a_r[31] ^ b_r[31];

  logic        sp;
  logic [31:0] sq;
  logic [4:0]  sf;

  // Special-case classification, in priority order
  always_comb begin
    sp = 1'b1;
    sq = 32'd0;
    sf = 5'd0;
    priority case (1'b1)
      (na | nb | (za & zb) | (ia & ib)): begin
        sq = 32'h7FC0_0000;
        sf = 5'b10000;
      end
      zb: begin
        sq = {sgn_c, 8'hFF, 23'd0};
        sf = 5'b01000;
      end
      ia: sq = {sgn_c, 8'hFF, 23'd0};
      ib: sq = {sgn_c, 31'd0};
      za: sq = {sgn_c, 31'd0};
      default: sp = 1'b0;
    endcase
  end

  logic        ge;
  logic [24:0] diff;

  assign ge   = (rem >= {1'b0, mb});
  assign diff = rem - {1'b0, mb};

  logic        hi, g, st, inc;
  logic [23:0] man;
  logic [24:0] man_r;
  logic [22:0] frac;
  logic signed [9:0] e1, e2;
  logic        ovf, unf;
  logic [31:0] rq;
  logic [4:0]  rf;

  always_comb begin
    hi    = quo[25];
    man   = hi ? quo[25:2] : quo[24:1];
    g     = hi ? quo[1] : quo[0];
    st    = (hi & quo[0]) | (rem != 25'd0);
    e1    = hi ? ex : ex - 10'sd1;
    inc   = g & (st | man[0]);
    man_r = {1'b0, man} + {24'd0, inc};
    // Mantissa carry leaves 1.0, whose fraction is zero
    frac  = man_r[24] ? man_r[23:1] : man_r[22:0];
    e2    = e1 + $signed({9'd0, man_r[24]});
    ovf   = (e2 >= 10'sd255);
    unf   = (e2 <= 10'sd0);
    rq    = {sgn, e2[7:0], frac};
    rf    = {4'd0, g | st};
    if (ovf) begin
      rq = {sgn, 8'hFF, 23'd0};
      rf = 5'b00101;
    end else if (unf) begin
      rq = {sgn, 31'd0};
      rf = 5'b00011;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (start) nxt = PREP;
      PREP: nxt = sp ? RND : DIV;
      DIV:  if (cnt == 5'd25) nxt = RND;
      RND:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      cnt    <= 5'd0;
      rem    <= 25'd0;
      mb     <= 24'd0;
      quo    <= 26'd0;
      ex     <= 10'sd0;
      sgn    <= 1'b0;
      spec   <= 1'b0;
      spec_q <= 32'd0;
`ifdef FPD_FLAGS_EN
      spec_f <= 5'd0;
      flags  <= 5'd0;
`endif
      q      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (nxt != IDLE);
      unique case (state)
        IDLE: begin
          if (start) begin
            a_r <= a;
            b_r <= b;
          end
        end
        PREP: begin
          sgn    <= sgn_c;
          spec   <= sp;
          spec_q <= sq;
`ifdef FPD_FLAGS_EN
          spec_f <= sf;
`endif
          rem    <= {2'b01, fa};
          mb     <= {1'b1, fb};
          ex     <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
          cnt    <= 5'd0;
          quo    <= 26'd0;
        end
        DIV: begin
          quo <= {quo[24:0], ge};
          rem <= ge ? {diff[23:0], 1'b0} : {rem[23:0], 1'b0};
          cnt <= cnt + 5'd1;
        end
        RND: begin
          done <= 1'b1;
          q    <= spec ? spec_q : rq;
`ifdef FPD_FLAGS_EN
          flags <= spec ? spec_f : rf;
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef FPD_FLAGS_EN
  logic unused_flags;
  assign unused_flags = ^{sf, rf};
`endif

endmodule

// File: tb/tb_fp_div_seq.sv
// Scoreboard bench for fp_div_seq: directed vectors with hand-derived results.
// A negedge monitor checks q, flags and latency whenever done pulses.
module tb_fp_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a, b, q;
  logic        busy, done;
`ifdef FPD_FLAGS_EN
  logic [4:0]  flags;
`endif

  fp_div_seq #(.size(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .q     (q),
    .busy  (busy),
    .done  (done)
`ifdef FPD_FLAGS_EN
    ,
    .flags (flags)
`endif
  );

  typedef struct {
    string       name;
    logic [31:0] q;
    logic [4:0]  f;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   npass = 0;
  int   ntot  = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_q"}, q, e.q);
        chk({e.name, "_lat"}, cyc, e.cyc);
        chk({e.name, "_busy_lo"}, {31'd0, busy}, 32'd0);
`ifdef FPD_FLAGS_EN
        chk({e.name, "_flags"}, {27'd0, flags}, {27'd0, e.f});
`endif
      end
    end
  end

  task automatic issue(input string nm, input logic [31:0] av,
                       input logic [31:0] bv, input logic [31:0] eq,
                       input logic [4:0] ef, input int lat,
                       input bit push);
    exp_t e;
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk({nm, "_busy_hi"}, {31'd0, busy}, 32'd1);
    if (push) begin
      e.name = nm;
      e.q    = eq;
      e.f    = ef;
      e.cyc  = cyc + lat;
      sb.push_back(e);
    end
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      chk("timeout", 32'd1, 32'd0);
      sb.delete();
    end
  endtask

  task automatic run(input string nm, input logic [31:0] av,
                     input logic [31:0] bv, input logic [31:0] eq,
                     input logic [4:0] ef, input int lat);
    issue(nm, av, bv, eq, ef, lat, 1'b1);
    wait_done();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_q", q, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
`ifdef FPD_FLAGS_EN
    chk("rst_flags", {27'd0, flags}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    run("div6_2",   32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28);
    run("div1_3",   32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 5'b00001, 28);
    run("div3_2",   32'h40400000, 32'h40000000, 32'h3FC00000, 5'b00000, 28);
    run("div1_1",   32'h3F800000, 32'h3F800000, 32'h3F800000, 5'b00000, 28);
    run("ovf",      32'h7F000000, 32'h3E800000, 32'h7F800000, 5'b00101, 28);
    run("unf",      32'h00800000, 32'h40000000, 32'h00000000, 5'b00011, 28);
    run("pdivz",    32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2);
    run("ndivz",    32'hBF800000, 32'h00000000, 32'hFF800000, 5'b01000, 2);
    run("zz",       32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000, 2);
    run("infinf",   32'h7F800000, 32'h7F800000, 32'h7FC00000, 5'b10000, 2);
    run("nan",      32'h7FC00001, 32'h40000000, 32'h7FC00000, 5'b10000, 2);
    run("inf_fin",  32'h7F800000, 32'hC0000000, 32'hFF800000, 5'b00000, 2);
    run("fin_inf",  32'h40000000, 32'h7F800000, 32'h00000000, 5'b00000, 2);
    run("nzero",    32'h80000000, 32'h40000000, 32'h80000000, 5'b00000, 2);

    // Back-to-back: second start asserted during the done cycle
    issue("b2b_a", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (done) break;
    end
    issue("b2b_b", 32'h3F800000, 32'h00000000, 32'h7F800000, 5'b01000, 2, 1'b1);
    wait_done();

    // Start while busy must be ignored
    issue("ign", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28, 1'b1);
    repeat (9) @(negedge clk);
    a     = 32'h3F800000;
    b     = 32'h00000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Reset mid-operation abandons the result
    issue("rstmid", 32'h3F800000, 32'h40400000, 32'h0, 5'b0, 28, 1'b0);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_q", q, 32'd0);
    chk("rstmid_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (35) @(negedge clk);
    chk("rstmid_idle", {31'd0, busy}, 32'd0);

    run("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 5'b00000, 28);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
